spif_arb: RTL
=============

Name: spif_arb

Overview:
- Arbitrates ownership of the single SPI flash byte engine (the f_* port) between two requesters.
  - A: code-fetch / boot-loader sequencer.
  - B: CPU I/O flash channel.
- A requester owns the engine for a whole SPI sequence, from chip-select assert to release, so bytes from the two sides never interleave.
- Sits between spif's requesters and the flash byte engine (flashsim in simulation); drives f_who to tag the owner.

Parameters:
- GAP, 2, idle cycles forced between one owner's release and the next grant (CS deselect time), 0..15.
- TMO, 0, owner-inactivity timeout in cycles with no byte write; 0 disables; 16-bit counter.

Ports:
- clk  in  1  system clock
- arstn  in  1  asynchronous active-low reset
- a_req  in  1  A requests/holds ownership; held high for the entire sequence
- a_wr  in  1  A byte-write strobe, single cycle
- a_dout  in  8  A byte to transmit
- a_format  in  3  A transfer format for this byte
- a_gnt  out  1  A owns the engine
- a_ready  out  1  A may issue a_wr this cycle
- b_req, b_wr, b_dout, b_format, b_gnt, b_ready: same as A, for requester B
- f_ready  in  1  engine ready for next byte
- f_wr  out  1  engine byte strobe
- f_who  out  1  owner of current byte: 0=A, 1=B
- f_dout  out  8  byte to engine
- f_format  out  3  format to engine
- err  out  1  one-cycle pulse: dropped write or timeout release

Behaviour:
- Reset state: all outputs 0, state IDLE, last=B (A wins the first tie), gap and timeout counters 0. Reset is asynchronous, also mid-sequence; the engine is not told, and requesters restart.
- States: IDLE, OWN_A, OWN_B, GAP.
- IDLE:
  - Only one req high → OWN of that requester.
  - Both high → OWN of the requester that is not `last` (round-robin).
  - Neither high → stay in IDLE.
  - x_gnt is registered: it rises the cycle after x_req is first sampled high (latency 1).
- OWN_x:
  - x_gnt=1.
  - x_ready = f_ready & ~inflight. The other side's ready and gnt are 0.
- Write path:
  - x_wr sampled with x_ready=1: next cycle f_wr=1 for exactly one cycle, f_dout/f_format = the sampled values, f_who = x.
  - inflight is set on the cycle x_wr is sampled and clears once f_ready has been sampled low then high again after f_wr. The engine guarantees f_ready low no later than the cycle after f_wr.
  - f_dout, f_format and f_who hold their values between writes.
- Dropped write: x_wr while ~x_ready, or from the non-owner → ignored, err pulses the next cycle.
- Release:
  - x_req low while in OWN_x with ~inflight → GAP, last=x, x_gnt drops next cycle.
  - x_req drops with inflight=1 → stay in OWN_x until inflight clears, then GAP.
- GAP:
  - Count GAP cycles, then IDLE.
  - GAP=0 → go directly to IDLE; the next grant is still one cycle later.
  - Requests arriving during GAP are held and evaluated in IDLE.
- Timeout (TMO≠0):
  - The counter resets on every accepted x_wr or on entry to OWN_x.
  - On reaching TMO with ~inflight → forced release to GAP, err pulse, last=x.
  - The owner then sees x_gnt=0 and must deassert x_req. A held req is re-requested normally: it re-enters IDLE arbitration and competes by round-robin.
- Simultaneous events:
  - x_wr in the same cycle as the x_req fall is accepted; release waits for inflight.
  - A req rise in the same cycle as the other side's release is arbitrated only after GAP.

Decomposition:
- Shared package (spif_pkg): state encoding, f_who constants (WHO_A=0, WHO_B=1), format width 3.
- Sub-module spif_arb_cnt: loadable down-counter used for both the GAP and TMO counts, two instances.
- Everything else stays in spif_arb.

Test Plan:
- Reset, a_req=1 alone → a_gnt=1 after one cycle. a_wr with a_dout=0x0B, a_format=1 → next cycle f_wr=1, f_dout=0x0B, f_format=1, f_who=0, single pulse.
- a_req and b_req rise in the same cycle after reset → A granted first. A releases → after GAP=2 idle cycles plus 1, b_gnt=1 and f_who=1 on B's first byte.
- B owns; b_req drops while a byte is inflight with f_ready held low for 10 cycles → b_gnt stays 1 until f_ready returns, then GAP, then A is granted.
- a_wr while a_ready=0 (inflight), and b_wr while A owns → no f_wr, err pulses once for each.
- TMO=20: A owns and issues no writes → at cycle 20 a_gnt=0 and err pulses; B pending → B granted after GAP.
- arstn low mid-sequence with f_wr pending → all outputs 0 immediately. After release, A is granted first on a tie.

Source files
------------

// File: rtl/spif_pkg.sv
// Shared definitions for the SPI flash engine arbiter: state encoding,
// owner tags driven on f_who, and datapath widths.
package spif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  localparam logic WHO_A = 1'b0;
  localparam logic WHO_B = 1'b1;

  localparam int FMT_W = 3;
  localparam int TMO_W = 16;
  localparam int GAP_W = 4;

endpackage

// File: rtl/spif_arb_cnt.sv
// Loadable saturating down-counter used to time the CS-deselect gap and
// the owner inactivity timeout.
module spif_arb_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // Load wins over decrement; counting stops at zero.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spif_arb.sv
// Two-requester arbiter for the SPI flash byte engine; one requester owns
// the engine for a whole chip-select sequence so bytes never interleave.
module spif_arb
  import spif_pkg::*;
#(
  parameter int unsigned GAP = 2,
  parameter int unsigned TMO = 0
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             a_req,
  input  logic             a_wr,
  input  logic [7:0]       a_dout,
  input  logic [FMT_W-1:0] a_format,
  output logic             a_gnt,
  output logic             a_ready,
  input  logic             b_req,
  input  logic             b_wr,
  input  logic [7:0]       b_dout,
  input  logic [FMT_W-1:0] b_format,
  output logic             b_gnt,
  output logic             b_ready,
  input  logic             f_ready,
  output logic             f_wr,
  output logic             f_who,
  output logic [7:0]       f_dout,
  output logic [FMT_W-1:0] f_format,
  output logic             err
);

  localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP == 0) ? '0 : GAP_W'(GAP - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = (TMO == 0) ? '0 : TMO_W'(TMO - 1);
  localparam logic             TMO_EN    = (TMO != 0);
  localparam arb_state_t       REL_STATE = (GAP == 0) ? ST_IDLE : ST_GAP;

  arb_state_t state, next_state;
  logic       last, next_last;
  logic       inflight, seen_low;
  logic       own_a, own_b, own_req;
  logic       acc_a, acc_b, accepted, drop;
  logic       tmo_rel, enter_own, enter_gap;
  logic       gap_zero, tmo_zero;

  assign own_a    = (state == ST_OWN_A);
  assign own_b    = (state == ST_OWN_B);
  assign own_req  = own_a ? a_req : b_req;

  assign a_gnt    = own_a;
  assign b_gnt    = own_b;
  assign a_ready  = own_a & f_ready & ~inflight;
  assign b_ready  = own_b & f_ready & ~inflight;

  assign acc_a    = a_wr & a_ready;
  assign acc_b    = b_wr & b_ready;
  assign accepted = acc_a | acc_b;
  assign drop     = (a_wr & ~a_ready) | (b_wr & ~b_ready);

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state <= ST_IDLE;
      last  <= WHO_B;
    end else begin
      state <= next_state;
      last  <= next_last;
    end
  end

  // A write accepted this cycle holds off release until its byte completes.
  always_comb begin
    next_state = state;
    next_last  = last;
    tmo_rel    = 1'b0;
    enter_own  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (a_req && (!b_req || (last == WHO_B))) begin
          next_state = ST_OWN_A;
          enter_own  = 1'b1;
        end else if (b_req) begin
          next_state = ST_OWN_B;
          enter_own  = 1'b1;
        end
      end
      ST_OWN_A, ST_OWN_B: begin
        if (!accepted && !inflight) begin
          if (!own_req) begin
            next_state = REL_STATE;
            next_last  = own_b ? WHO_B : WHO_A;
          end else if (TMO_EN && tmo_zero) begin
            next_state = REL_STATE;
            next_last  = own_b ? WHO_B : WHO_A;
            tmo_rel    = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_zero) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  assign enter_gap = (next_state == ST_GAP) && (state != ST_GAP);

  spif_arb_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk      (clk),
    .arstn    (arstn),
    .load     (enter_gap),
    .load_val (GAP_LOAD),
    .dec      (state == ST_GAP),
    .zero     (gap_zero)
  );

  spif_arb_cnt #(.W(TMO_W)) u_tmo_cnt (
    .clk      (clk),
    .arstn    (arstn),
    .load     (enter_own | accepted),
    .load_val (TMO_LOAD),
    .dec      (own_a | own_b),
    .zero     (tmo_zero)
  );

  // A byte stays inflight until the engine has shown busy (f_ready low) and
  // then come back ready.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      f_wr     <= 1'b0;
      f_who    <= WHO_A;
      f_dout   <= '0;
      f_format <= '0;
      err      <= 1'b0;
      inflight <= 1'b0;
      seen_low <= 1'b0;
    end else begin
      f_wr <= accepted;
      err  <= drop | tmo_rel;
      if (acc_a) begin
        f_dout   <= a_dout;
        f_format <= a_format;
        f_who    <= WHO_A;
      end else if (acc_b) begin
        f_dout   <= b_dout;
        f_format <= b_format;
        f_who    <= WHO_B;
      end
      if (accepted) begin
        inflight <= 1'b1;
        seen_low <= 1'b0;
      end else if (inflight) begin
        if (!f_ready) begin
          seen_low <= 1'b1;
        end else if (seen_low) begin
          inflight <= 1'b0;
          seen_low <= 1'b0;
        end
      end
    end
  end

endmodule
